// File: rtl/input_wait_ctrl_pkg.sv
// input_wait_ctrl_pkg: FSM state encoding and debounce defaults for the IN-instruction input sequencer.
package input_wait_ctrl_pkg;
   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_RELEASE = 3'd1,
      WAIT_PRESS   = 3'd2,
      CAPTURE      = 3'd3,
      DONE         = 3'd4,
      HOLD         = 3'd5
   } state_e;
   localparam int DEBOUNCE_SIM = 4;
   localparam int DEBOUNCE_SYN = 50000;
endpackage

// File: rtl/input_wait_ctrl_debouncer.sv
// input_debouncer: 2-flop synchronizer, stability counter and rising-edge detect for the push-button.
module input_debouncer
   import input_wait_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_SIM,
   parameter int CNT_W        = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bot,
   output logic clean,
   output logic press
);
   logic             s1_q, s2_q, clean_q, clean_d, clean_d1_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // clean only flips after the synchronized level has disagreed for DEBOUNCE_CYC cycles
   always_comb begin
      cnt_d   = '0;
      clean_d = clean_q;
      if (s2_q != clean_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) clean_d = s2_q;
         else cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         clean_q    <= 1'b0;
         clean_d1_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_q       <= bot;
         s2_q       <= s1_q;
         clean_q    <= clean_d;
         clean_d1_q <= clean_q;
         cnt_q      <= cnt_d;
      end
   end

   assign clean = clean_q;
   assign press = clean_q & ~clean_d1_q;
endmodule

// File: rtl/input_wait_ctrl.sv
// input_wait_ctrl: waits for one debounced button press per IN request and returns the switch word with a one-cycle ack.
module input_wait_ctrl
   import input_wait_ctrl_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int DEBOUNCE_CYC = DEBOUNCE_SIM,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              bot,
   input  logic [DATA_W-1:0] sw,
   output logic [DATA_W-1:0] data_out,
   output logic              ack,
   output logic              busy,
   output logic              wait_led
);
   state_e            state_q, state_d;
   logic              clean, press, ack_q;
   logic [DATA_W-1:0] sw1_q, sw_s_q, data_q;

   input_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .bot   (bot),
      .clean (clean),
      .press (press)
   );

   // abort on req drop takes priority over a coincident press
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:         state_d = req ? (clean ? WAIT_RELEASE : WAIT_PRESS) : IDLE;
         WAIT_RELEASE: state_d = !req ? IDLE : (clean ? WAIT_RELEASE : WAIT_PRESS);
         WAIT_PRESS:   state_d = !req ? IDLE : (press ? CAPTURE : WAIT_PRESS);
         CAPTURE:      state_d = DONE;
         DONE:         state_d = req ? HOLD : IDLE;
         HOLD:         state_d = req ? HOLD : IDLE;
         default:      state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sw1_q   <= '0;
         sw_s_q  <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sw1_q   <= sw;
         sw_s_q  <= sw1_q;
         ack_q   <= (state_q == CAPTURE);
         if (state_q == CAPTURE) data_q <= sw_s_q;
      end
   end

   assign data_out = data_q;
   assign ack      = ack_q;
   assign wait_led = (state_q == WAIT_PRESS);
   assign busy     = (state_q inside {WAIT_RELEASE, WAIT_PRESS, CAPTURE}) | ((state_q == IDLE) & req);
endmodule

// File: tb/tb_input_wait_ctrl.sv
// tb_input_wait_ctrl: directed self-checking bench for the IN-instruction button/switch sequencer.
module tb_input_wait_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, req, bot;
   logic [15:0] sw;
   logic [15:0] data_out;
   logic        ack, busy, wait_led;
   int          checks = 0;
   int          failures = 0;

   input_wait_ctrl #(.DATA_W(16), .DEBOUNCE_CYC(4), .CNT_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .bot      (bot),
      .sw       (sw),
      .data_out (data_out),
      .ack      (ack),
      .busy     (busy),
      .wait_led (wait_led)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req = 1'b0; bot = 1'b0; sw = 16'h0;
      settle(2);
      checks++;
      if ({ack, busy, wait_led, data_out} !== {3'b000, 16'h0}) begin
         failures++;
         $display("FAIL reset_outputs: ack/busy/led/data=%b/%b/%b/%h want 0/0/0/0000", ack, busy, wait_led, data_out);
      end
      rst_n = 1'b1;
      settle(2);
      checks++;
      if ({ack, busy, wait_led} !== 3'b000) begin
         failures++;
         $display("FAIL reset_release_idle: ack/busy/led=%b/%b/%b want 0/0/0", ack, busy, wait_led);
      end
   endtask

   task automatic test_single_press;
      sw = 16'hA5A5; req = 1'b1; bot = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy} !== {i == 8, i < 8}) begin
            failures++;
            $display("FAIL single_press cyc%0d: ack/busy=%b/%b want %b/%b", i, ack, busy, i == 8, i < 8);
         end
         if (i == 8) begin
            checks++;
            if (data_out !== 16'hA5A5) begin
               failures++;
               $display("FAIL single_press_data: data_out=%h want a5a5", data_out);
            end
         end
         if (i == 10) bot = 1'b0;
      end
      req = 1'b0;
      settle(8);
      checks++;
      if ({ack, busy, wait_led, data_out} !== {3'b000, 16'hA5A5}) begin
         failures++;
         $display("FAIL single_press_idle: ack/busy/led/data=%b/%b/%b/%h want 0/0/0/a5a5", ack, busy, wait_led, data_out);
      end
   endtask

   task automatic test_glitch;
      req = 1'b1; bot = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, wait_led} !== 2'b11) begin
         failures++;
         $display("FAIL glitch_wait: busy/led=%b/%b want 1/1", busy, wait_led);
      end
      for (int i = 0; i < 18; i++) begin
         bot = (i < 12) && ((i % 4) < 2);
         @(negedge clk);
         checks++;
         if ({ack, busy, wait_led} !== 3'b011) begin
            failures++;
            $display("FAIL glitch cyc%0d: ack/busy/led=%b/%b/%b want 0/1/1", i, ack, busy, wait_led);
         end
      end
      checks++;
      if (data_out !== 16'hA5A5) begin
         failures++;
         $display("FAIL glitch_data: data_out=%h want a5a5", data_out);
      end
      req = 1'b0;
      @(negedge clk);
      checks++;
      if ({ack, busy, wait_led} !== 3'b000) begin
         failures++;
         $display("FAIL glitch_abort: ack/busy/led=%b/%b/%b want 0/0/0", ack, busy, wait_led);
      end
   endtask

   task automatic test_held_before_req;
      bot = 1'b1; sw = 16'h1234;
      settle(8);
      req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy, wait_led} !== 3'b010) begin
            failures++;
            $display("FAIL held_wait_release cyc%0d: ack/busy/led=%b/%b/%b want 0/1/0", i, ack, busy, wait_led);
         end
      end
      bot = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy} !== 2'b01) begin
            failures++;
            $display("FAIL held_release cyc%0d: ack/busy=%b/%b want 0/1", i, ack, busy);
         end
      end
      checks++;
      if (wait_led !== 1'b1) begin
         failures++;
         $display("FAIL held_prompt: wait_led=%b want 1", wait_led);
      end
      sw = 16'hBEEF; bot = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         checks++;
         if (ack !== (i == 8)) begin
            failures++;
            $display("FAIL held_new_press cyc%0d: ack=%b want %b", i, ack, i == 8);
         end
         if (i == 8) begin
            checks++;
            if (data_out !== 16'hBEEF) begin
               failures++;
               $display("FAIL held_data: data_out=%h want beef", data_out);
            end
         end
      end
      req = 1'b0; bot = 1'b0;
      settle(8);
   endtask

   task automatic test_abort;
      req = 1'b1; bot = 1'b0;
      settle(3);
      checks++;
      if (wait_led !== 1'b1) begin
         failures++;
         $display("FAIL abort_prompt: wait_led=%b want 1", wait_led);
      end
      req = 1'b0;
      @(negedge clk);
      checks++;
      if ({ack, busy, wait_led} !== 3'b000) begin
         failures++;
         $display("FAIL abort_idle: ack/busy/led=%b/%b/%b want 0/0/0", ack, busy, wait_led);
      end
      bot = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy, data_out} !== {2'b00, 16'hBEEF}) begin
            failures++;
            $display("FAIL abort_late_press cyc%0d: ack/busy/data=%b/%b/%h want 0/0/beef", i, ack, busy, data_out);
         end
      end
      bot = 1'b0;
      settle(8);
      // press pulse and req drop land in the same WAIT_PRESS cycle
      req = 1'b1; bot = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy} !== {1'b0, i <= 6}) begin
            failures++;
            $display("FAIL abort_vs_press cyc%0d: ack/busy=%b/%b want 0/%b", i, ack, busy, i <= 6);
         end
         if (i == 6) req = 1'b0;
      end
      bot = 1'b0;
      settle(8);
   endtask

   task automatic test_back_to_back;
      sw = 16'h0F0F; req = 1'b1; bot = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy} !== {i == 8, i < 8}) begin
            failures++;
            $display("FAIL hold_first cyc%0d: ack/busy=%b/%b want %b/%b", i, ack, busy, i == 8, i < 8);
         end
         if (i == 8) begin
            checks++;
            if (data_out !== 16'h0F0F) begin
               failures++;
               $display("FAIL hold_first_data: data_out=%h want 0f0f", data_out);
            end
         end
      end
      req = 1'b0;
      @(negedge clk);
      checks++;
      if ({ack, busy} !== 2'b00) begin
         failures++;
         $display("FAIL hold_exit: ack/busy=%b/%b want 0/0", ack, busy);
      end
      req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy, wait_led} !== 3'b010) begin
            failures++;
            $display("FAIL hold_rereq cyc%0d: ack/busy/led=%b/%b/%b want 0/1/0", i, ack, busy, wait_led);
         end
      end
      bot = 1'b0;
      settle(8);
      checks++;
      if ({ack, wait_led} !== 2'b01) begin
         failures++;
         $display("FAIL hold_rearm: ack/led=%b/%b want 0/1", ack, wait_led);
      end
      sw = 16'hF00F; bot = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         checks++;
         if (ack !== (i == 8)) begin
            failures++;
            $display("FAIL hold_second cyc%0d: ack=%b want %b", i, ack, i == 8);
         end
         if (i == 8) begin
            checks++;
            if (data_out !== 16'hF00F) begin
               failures++;
               $display("FAIL hold_second_data: data_out=%h want f00f", data_out);
            end
         end
      end
      req = 1'b0; bot = 1'b0;
      settle(8);
   endtask

   task automatic test_reset_mid;
      req = 1'b1; bot = 1'b0;
      settle(2);
      checks++;
      if (wait_led !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_prompt: wait_led=%b want 1", wait_led);
      end
      #2 rst_n = 1'b0; req = 1'b0;
      #1;
      checks++;
      if ({ack, busy, wait_led, data_out} !== {3'b000, 16'h0}) begin
         failures++;
         $display("FAIL rst_wait_press: ack/busy/led/data=%b/%b/%b/%h want 0/0/0/0000", ack, busy, wait_led, data_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      settle(1);
      sw = 16'h5A5A; req = 1'b1; bot = 1'b1;
      settle(7);
      checks++;
      if ({ack, busy, wait_led} !== 3'b010) begin
         failures++;
         $display("FAIL rst_capture_state: ack/busy/led=%b/%b/%b want 0/1/0", ack, busy, wait_led);
      end
      #2 rst_n = 1'b0; req = 1'b0; bot = 1'b0;
      #1;
      checks++;
      if ({ack, busy, wait_led, data_out} !== {3'b000, 16'h0}) begin
         failures++;
         $display("FAIL rst_capture: ack/busy/led/data=%b/%b/%b/%h want 0/0/0/0000", ack, busy, wait_led, data_out);
      end
      @(negedge clk);
      checks++;
      if ({ack, data_out} !== {1'b0, 16'h0}) begin
         failures++;
         $display("FAIL rst_capture_hold: ack/data=%b/%h want 0/0000", ack, data_out);
      end
      rst_n = 1'b1;
      settle(8);
      sw = 16'hC3C3; req = 1'b1; bot = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         checks++;
         if ({ack, busy} !== {i == 8, i < 8}) begin
            failures++;
            $display("FAIL rst_resume cyc%0d: ack/busy=%b/%b want %b/%b", i, ack, busy, i == 8, i < 8);
         end
         if (i == 8) begin
            checks++;
            if (data_out !== 16'hC3C3) begin
               failures++;
               $display("FAIL rst_resume_data: data_out=%h want c3c3", data_out);
            end
         end
      end
      req = 1'b0; bot = 1'b0;
      settle(4);
   endtask

   initial begin
      test_reset;
      test_single_press;
      test_glitch;
      test_held_before_req;
      test_abort;
      test_back_to_back;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
